uart_rx_deser: RTL and testbench
================================

// Module: uart_rx_deser
// PURPOSE
//  UART receive deserializer feeding the RX FIFO write port (din/wr_en) and uart_control status.
//  Synchronizes the async Rx line, oversamples each bit, majority-votes mid-bit, assembles LSB-first
//  frames (start, DATA_BITS data, 1 stop) and pushes each good byte as a one-cycle write strobe.
//  Reports framing and overrun errors as pulses plus sticky flags.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..8)
//  OVERSAMPLE  16  baud ticks per bit (fixed 16; sample points below assume 16)
// PORTS
//  Clk          in   1   system clock
//  Rst          in   1   asynchronous, active-high reset
//  Rx           in   1   UART RX line, asynchronous, idle high
//  rx_en_i      in   1   receiver enable (from control register)
//  baud_div_i   in   16  Clk cycles per baud tick; tick rate = 16 x baud
//  fifo_full_i  in   1   RX FIFO full
//  rx_data_o    out  8   received byte, zero-extended above DATA_BITS; valid with rx_wr_o
//  rx_wr_o      out  1   one-cycle RX FIFO write strobe
//  frame_err_o  out  1   one-cycle pulse: stop bit sampled 0
//  overrun_o    out  1   one-cycle pulse: good byte dropped, FIFO full
//  err_clr_i    in   1   clears sticky flags
//  frame_sticky_o out 1  sticky framing error
//  ovr_sticky_o out  1   sticky overrun
//  busy_o       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: sync flops=1, state IDLE, all counters 0, all outputs 0 (rx_data_o=0).
//  Sync: 2-flop synchronizer on Rx; rx_s = 2nd flop; rx_d = rx_s delayed 1 cycle (edge detect).
//  Tick gen: cnt counts 0..baud_div_i-1, tick=1 when cnt==baud_div_i-1, then wraps to 0.
//   baud_div_i==0: no ticks, FSM held in IDLE. Values 1..65535 legal; 1 = tick every cycle.
//  Sample counter s: 0..15, +1 per tick, wraps 15->0 and bit index advances on wrap.
//  Vote: rx_s captured on ticks at s=7,8,9; bit = majority(3), decided on the s=9 tick.
//  FSM:
//   IDLE : falling edge (rx_d=1, rx_s=0) and rx_en_i and baud_div_i!=0 -> START;
//          tick cnt and s cleared to 0 on entry.
//   START: on decision: bit=1 -> IDLE (false start, no strobe/error); bit=0 -> DATA at s wrap.
//   DATA : on each decision shift bit into shreg MSB side (LSB first on wire); after DATA_BITS
//          bits -> STOP at s wrap.
//   STOP : on decision -> IDLE immediately (do not wait for end of stop bit):
//          bit=1, !fifo_full_i : rx_data_o<=shreg, rx_wr_o=1 next cycle for exactly 1 cycle.
//          bit=1,  fifo_full_i : overrun_o=1 for 1 cycle, ovr_sticky_o<=1, no strobe.
//          bit=0               : frame_err_o=1 for 1 cycle, frame_sticky_o<=1, no strobe.
//  fifo_full_i is sampled only on the STOP decision cycle.
//  Latency: rx_wr_o rises 1 Clk after the STOP-bit s=9 tick; rx_data_o holds until next write.
//  Next frame: IDLE requires a fresh falling edge; line held low after frame error (break)
//   produces no further frames until it returns high and falls again.
//  rx_en_i=0: next cycle FSM forced IDLE, partial frame discarded, no strobe/errors;
//   sticky flags and rx_data_o retained.
//  Sticky: set has priority over err_clr_i in the same cycle.
//  baud_div_i changed mid-frame: takes effect at next tick compare; no abort required.
//  Async Rst mid-frame: everything returns to reset values immediately; no strobe.
// TESTING (baud_div_i=4 -> 64 Clk per bit unless stated)
//  1 rx_en=1, send 0xA5 (8N1) -> single rx_wr_o pulse, rx_data_o=0xA5, ~9.6 bit times after start edge, no errors.
//  2 Rx low 3 Clk glitch, then high -> START rejects, busy_o drops by s=9 tick, no strobe/error.
//  3 send 0x3C with stop bit 0 -> frame_err_o 1-cycle pulse, frame_sticky_o=1, no rx_wr_o; err_clr_i -> 0.
//  4 fifo_full_i=1, send 0x55 -> overrun_o pulse, ovr_sticky_o=1, no rx_wr_o; then full=0, 0x55 -> written.
//  5 rx_en_i dropped during data bit 3 of 0x0F, re-enabled, send 0x81 -> exactly one strobe, data 0x81.
//  6 baud_div_i=1, back-to-back 0x00,0xFF, 0x7E (no idle gap) -> three strobes with those values in order;
//    Rst pulsed mid-frame of a 4th byte -> no strobe, all outputs 0.

Source files
------------

// File: rtl/uart_rx_deser_if.sv
// FIFO write port and control/status bundle between the UART receiver and its
// RX FIFO / control block.
interface uart_rx_deser_if;
  logic        rx_en_i;
  logic [15:0] baud_div_i;
  logic        fifo_full_i;
  logic        err_clr_i;
  logic [7:0]  rx_data_o;
  logic        rx_wr_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        frame_sticky_o;
  logic        ovr_sticky_o;
  logic        busy_o;

  modport slave (
    input  rx_en_i, baud_div_i, fifo_full_i, err_clr_i,
    output rx_data_o, rx_wr_o, frame_err_o, overrun_o,
    output frame_sticky_o, ovr_sticky_o, busy_o
  );

  modport master (
    output rx_en_i, baud_div_i, fifo_full_i, err_clr_i,
    input  rx_data_o, rx_wr_o, frame_err_o, overrun_o,
    input  frame_sticky_o, ovr_sticky_o, busy_o
  );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: synchronizes Rx, 16x oversamples with a 3-point
// mid-bit majority vote, and pushes good bytes to the RX FIFO as 1-cycle strobes.
module uart_rx_deser #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Rx,
  uart_rx_deser_if.slave bus
);
  localparam int         BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 r_state, w_next;
  logic                   r_sync1, r_sync2, r_rx_d;
  logic [15:0]            r_cnt;
  logic [3:0]             r_s;
  logic [BIT_W-1:0]       r_bit_idx;
  logic                   r_v7, r_v8;
  logic [DATA_BITS-1:0]   r_shreg;
  logic [7:0]             r_data;
  logic                   r_wr, r_ferr, r_ovr, r_fsticky, r_osticky;

  logic w_tick, w_fall, w_decide, w_wrap, w_bit;
  logic w_start, w_shift, w_bit_adv, w_push, w_ferr, w_ovr;

  assign w_tick   = (bus.baud_div_i != 16'd0) && (r_cnt == bus.baud_div_i - 16'd1);
  assign w_fall   = r_rx_d & ~r_sync2;
  assign w_decide = w_tick && (r_s == 4'd9);
  assign w_wrap   = w_tick && (r_s == S_LAST);
  // Third vote is the live synchronized line on the s=9 tick itself.
  assign w_bit    = (r_v7 & r_v8) | (r_v7 & r_sync2) | (r_v8 & r_sync2);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= Rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_shift   = 1'b0;
    w_bit_adv = 1'b0;
    w_push    = 1'b0;
    w_ferr    = 1'b0;
    w_ovr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall && bus.rx_en_i && (bus.baud_div_i != 16'd0)) begin
          w_next  = START;
          w_start = 1'b1;
        end
      end
      START: begin
        if (w_decide && w_bit) w_next = IDLE;
        else if (w_wrap)       w_next = DATA;
      end
      DATA: begin
        w_shift = w_decide;
        if (w_wrap) begin
          if (r_bit_idx == BIT_W'(DATA_BITS - 1)) w_next = STOP;
          else                                   w_bit_adv = 1'b1;
        end
      end
      STOP: begin
        if (w_decide) begin
          w_next = IDLE;
          if (!w_bit)                w_ferr = 1'b1;
          else if (bus.fifo_full_i)  w_ovr  = 1'b1;
          else                       w_push = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    // Disabling the receiver abandons any partial frame silently.
    if (!bus.rx_en_i) begin
      w_next    = IDLE;
      w_start   = 1'b0;
      w_shift   = 1'b0;
      w_bit_adv = 1'b0;
      w_push    = 1'b0;
      w_ferr    = 1'b0;
      w_ovr     = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt     <= 16'd0;
      r_s       <= 4'd0;
      r_bit_idx <= '0;
    end else if (w_start) begin
      r_cnt     <= 16'd0;
      r_s       <= 4'd0;
      r_bit_idx <= '0;
    end else begin
      if ((bus.baud_div_i == 16'd0) || w_tick) r_cnt <= 16'd0;
      else                                     r_cnt <= r_cnt + 16'd1;
      if ((r_state != IDLE) && w_tick) r_s <= (r_s == S_LAST) ? 4'd0 : r_s + 4'd1;
      if (w_bit_adv) r_bit_idx <= r_bit_idx + BIT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_v7      <= 1'b0;
      r_v8      <= 1'b0;
      r_shreg   <= '0;
      r_data    <= 8'd0;
      r_wr      <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_fsticky <= 1'b0;
      r_osticky <= 1'b0;
    end else begin
      if (w_tick && (r_s == 4'd7)) r_v7 <= r_sync2;
      if (w_tick && (r_s == 4'd8)) r_v8 <= r_sync2;
      if (w_shift) r_shreg <= {w_bit, r_shreg[DATA_BITS-1:1]};
      if (w_push)  r_data  <= 8'(r_shreg);
      r_wr   <= w_push;
      r_ferr <= w_ferr;
      r_ovr  <= w_ovr;
      if (w_ferr)             r_fsticky <= 1'b1;
      else if (bus.err_clr_i) r_fsticky <= 1'b0;
      if (w_ovr)              r_osticky <= 1'b1;
      else if (bus.err_clr_i) r_osticky <= 1'b0;
    end
  end

  assign bus.rx_data_o      = r_data;
  assign bus.rx_wr_o        = r_wr;
  assign bus.frame_err_o    = r_ferr;
  assign bus.overrun_o      = r_ovr;
  assign bus.frame_sticky_o = r_fsticky;
  assign bus.ovr_sticky_o   = r_osticky;
  assign bus.busy_o         = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: stimulus queues expected FIFO writes and
// error pulses, a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_rx_deser;
  localparam int EV_WR   = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic Rx  = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   bit_clks = 64;
  int   last_wr_cyc = 0;
  int   t_edge = 0;
  ev_t  exp_q[$];

  uart_rx_deser_if bus_if ();

  uart_rx_deser dut (
    .Clk (Clk),
    .Rst (Rst),
    .Rx  (Rx),
    .bus (bus_if)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind, input logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual_kind=%0d data=%0h required=none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_WR && e.data !== data)) begin
        failures++;
        $display("FAIL event actual_kind=%0d data=%0h required_kind=%0d data=%0h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst) begin
      if (bus_if.rx_wr_o) begin
        last_wr_cyc = cyc;
        mon_event(EV_WR, bus_if.rx_data_o);
      end
      if (bus_if.frame_err_o) mon_event(EV_FERR, 8'h00);
      if (bus_if.overrun_o)   mon_event(EV_OVR, 8'h00);
    end
  end

  task automatic send_bit(input logic b);
    Rx = b;
    repeat (bit_clks) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_b);
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  function automatic logic [14:0] outs();
    return {bus_if.rx_data_o, bus_if.rx_wr_o, bus_if.frame_err_o, bus_if.overrun_o,
            bus_if.frame_sticky_o, bus_if.ovr_sticky_o, bus_if.busy_o, 1'b0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus_if.rx_en_i     = 1'b0;
    bus_if.baud_div_i  = 16'd4;
    bus_if.fifo_full_i = 1'b0;
    bus_if.err_clr_i   = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", 32'(outs()), 32'h0);
    Rst = 1'b0;
    bus_if.rx_en_i = 1'b1;
    idle(10);

    // Test 1: clean 0xA5 with latency window around 9.6 bit times.
    push_ev(EV_WR, 8'hA5);
    t_edge = cyc;
    send_frame(8'hA5, 1'b1);
    idle(40);
    chk("t1_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_latency_window", 32'((last_wr_cyc - t_edge >= 600) && (last_wr_cyc - t_edge <= 640)), 32'd1);
    chk("t1_no_sticky", {30'd0, bus_if.frame_sticky_o, bus_if.ovr_sticky_o}, 32'd0);

    // Test 2: 3-cycle glitch is rejected as a false start.
    Rx = 1'b0;
    repeat (3) @(negedge Clk);
    Rx = 1'b1;
    repeat (6) @(negedge Clk);
    chk("t2_busy_after_glitch", 32'(bus_if.busy_o), 32'd1);
    repeat (64) @(negedge Clk);
    chk("t2_busy_dropped", 32'(bus_if.busy_o), 32'd0);
    idle(64);
    chk("t2_no_events", 32'(exp_q.size()), 32'd0);

    // Test 3: bad stop bit.
    push_ev(EV_FERR, 8'h00);
    send_frame(8'h3C, 1'b0);
    idle(20);
    chk("t3_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_frame_sticky", 32'(bus_if.frame_sticky_o), 32'd1);
    chk("t3_data_retained", 32'(bus_if.rx_data_o), 32'hA5);
    bus_if.err_clr_i = 1'b1;
    @(negedge Clk);
    bus_if.err_clr_i = 1'b0;
    @(negedge Clk);
    chk("t3_sticky_cleared", 32'(bus_if.frame_sticky_o), 32'd0);

    // Test 4: overrun while FIFO full, then a normal write.
    bus_if.fifo_full_i = 1'b1;
    push_ev(EV_OVR, 8'h00);
    send_frame(8'h55, 1'b1);
    idle(20);
    chk("t4_ovr_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_ovr_sticky", 32'(bus_if.ovr_sticky_o), 32'd1);
    chk("t4_data_retained", 32'(bus_if.rx_data_o), 32'hA5);
    bus_if.fifo_full_i = 1'b0;
    push_ev(EV_WR, 8'h55);
    send_frame(8'h55, 1'b1);
    idle(20);
    chk("t4_wr_queue_drained", 32'(exp_q.size()), 32'd0);
    bus_if.err_clr_i = 1'b1;
    @(negedge Clk);
    bus_if.err_clr_i = 1'b0;
    @(negedge Clk);
    chk("t4_sticky_cleared", 32'(bus_if.ovr_sticky_o), 32'd0);

    // Test 5: disable during data bit 3, then receive 0x81.
    fork
      send_frame(8'h0F, 1'b1);
      begin
        repeat (64 * 4 + 32) @(negedge Clk);
        bus_if.rx_en_i = 1'b0;
        repeat (2) @(negedge Clk);
        chk("t5_busy_forced_idle", 32'(bus_if.busy_o), 32'd0);
      end
    join
    idle(20);
    bus_if.rx_en_i = 1'b1;
    idle(20);
    chk("t5_nothing_from_aborted", 32'(exp_q.size()), 32'd0);
    push_ev(EV_WR, 8'h81);
    send_frame(8'h81, 1'b1);
    idle(20);
    chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);

    // Test 6: fastest baud, back-to-back frames, then reset mid-frame.
    bus_if.baud_div_i = 16'd1;
    bit_clks = 16;
    idle(20);
    push_ev(EV_WR, 8'h00);
    push_ev(EV_WR, 8'hFF);
    push_ev(EV_WR, 8'h7E);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h7E, 1'b1);
    idle(10);
    chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_last_data", 32'(bus_if.rx_data_o), 32'h7E);
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (16 * 4) @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("t6_async_reset_outputs", 32'(outs()), 32'h0);
      end
    join
    chk("t6_reset_held_outputs", 32'(outs()), 32'h0);
    idle(5);
    Rst = 1'b0;
    idle(40);
    chk("t6_after_reset_outputs", 32'(outs()), 32'h0);
    chk("t6_no_events", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
